get_cert_responder: RTL and testbench

Responder-side counterpart of the GET_CERTIFICATE request path. It accepts one decoded GET_CERTIFICATE request (header plus offset/length payload), validates the slot and offset against the provisioned certificate chains, and streams the requested portion of the chain out of an external byte ROM. When the stream completes, or the request is rejected, it reports the CERTIFICATE response header, portion length, remainder length and error code with a one-cycle acknowledge. It sits between the message decoder and the transmit framer on the responder end of the authentication link.

---
 rtl/get_cert_responder_pkg.sv | 58 +++++
 rtl/get_cert_responder_if.sv | 34 +++
 rtl/get_cert_responder_cert_chain_len.sv | 28 ++
 rtl/get_cert_responder.sv | 128 ++++++++++++
 tb/tb_get_cert_responder.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/get_cert_responder_pkg.sv
// Shared header encodings, certificate-chain sizes, ROM slot bases, error codes and
// state type for the GET_CERTIFICATE responder.
`ifndef GET_CERT_RESPONDER_DEFINES
`define GET_CERT_RESPONDER_DEFINES
`define SIZE_OF_HEADER_VARS      4
`define SIZE_OF_HEADER_IN_BYTES  8
`define MSG_LEN                  64
`define HEADER_CERTIFICATE_SLOT0 32'h1082_0000
`define HEADER_CERTIFICATE_SLOT1 32'h1082_0100
`define HEADER_CERTIFICATE_SLOT2 32'h1082_0200
`define HEADER_CERTIFICATE_RESP  32'h1002_0000
`define HEADER_ERROR_RESP        32'h107F_0000
`define SLOT0_CERT0_LENGTH 120
`define SLOT0_CERT1_LENGTH 110
`define SLOT0_CERT2_LENGTH 100
`define SLOT0_CERT3_LENGTH 130
`define SLOT0_CERT4_LENGTH 90
`define SLOT0_CERT5_LENGTH 80
`define SLOT1_CERT0_LENGTH 50
`define SLOT1_CERT1_LENGTH 60
`define SLOT1_CERT2_LENGTH 40
`define SLOT1_CERT3_LENGTH 30
`define SLOT2_CERT0_LENGTH 20
`define SLOT2_CERT1_LENGTH 30
`define SLOT2_CERT2_LENGTH 25
`define SLOT2_CERT3_LENGTH 15
`define SLOT2_CERT4_LENGTH 10
`endif

package get_cert_responder_pkg;
  localparam int HDR_W = `SIZE_OF_HEADER_VARS * `SIZE_OF_HEADER_IN_BYTES;
  localparam int PAY_W = `MSG_LEN - HDR_W;

  localparam logic [HDR_W-1:0] HEADER_CERTIFICATE_RESP = `HEADER_CERTIFICATE_RESP;
  localparam logic [HDR_W-1:0] HEADER_ERROR_RESP       = `HEADER_ERROR_RESP;

  localparam int SLOT0_BASE = 0;
  localparam int SLOT1_BASE = 1024;
  localparam int SLOT2_BASE = 2048;

  localparam logic [7:0] ERR_NONE            = 8'h00;
  localparam logic [7:0] ERR_INVALID_REQUEST = 8'h01;
  localparam logic [7:0] ERR_INVALID_OFFSET  = 8'h02;

  typedef enum logic [2:0] {IDLE, DECODE, FETCH, WAIT, SEND, DONE} state_t;
  typedef enum logic [1:0] {SLOT_0, SLOT_1, SLOT_2, SLOT_NONE} slot_t;

  function automatic slot_t slot_of(input logic [HDR_W-1:0] hdr);
    if (hdr == `HEADER_CERTIFICATE_SLOT0) return SLOT_0;
    if (hdr == `HEADER_CERTIFICATE_SLOT1) return SLOT_1;
    if (hdr == `HEADER_CERTIFICATE_SLOT2) return SLOT_2;
    return SLOT_NONE;
  endfunction

  function automatic logic [16:0] min17(input logic [16:0] a, input logic [16:0] b);
    return (a < b) ? a : b;
  endfunction
endpackage

// File: rtl/get_cert_responder_if.sv
// Request, ROM and transmit signals of the GET_CERTIFICATE responder.
interface get_cert_responder_if
  import get_cert_responder_pkg::*;
#(
  parameter int ROM_AW = 12
);
  logic              Enable;
  logic [HDR_W-1:0]  header;
  logic [PAY_W-1:0]  payload;
  logic [ROM_AW-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_last;
  logic [HDR_W-1:0]  resp_header;
  logic [15:0]       portion_len;
  logic [15:0]       remainder_len;
  logic [7:0]        error_code;
  logic              Ack_out;
  logic              busy;

  modport master (
    output Enable, header, payload, rom_data, tx_ready,
    input  rom_addr, tx_data, tx_valid, tx_last, resp_header,
           portion_len, remainder_len, error_code, Ack_out, busy
  );

  modport slave (
    input  Enable, header, payload, rom_data, tx_ready,
    output rom_addr, tx_data, tx_valid, tx_last, resp_header,
           portion_len, remainder_len, error_code, Ack_out, busy
  );
endinterface

// File: rtl/get_cert_responder_cert_chain_len.sv
// Combinational lookup of certificate-chain length and ROM base address per slot.
module cert_chain_len
  import get_cert_responder_pkg::*;
#(
  parameter int ROM_AW = 12
) (
  input  slot_t             slot,
  output logic [16:0]       chain_len,
  output logic [ROM_AW-1:0] base
);
  localparam logic [16:0] CHAIN0 = 17'(`SLOT0_CERT0_LENGTH + `SLOT0_CERT1_LENGTH +
    `SLOT0_CERT2_LENGTH + `SLOT0_CERT3_LENGTH + `SLOT0_CERT4_LENGTH + `SLOT0_CERT5_LENGTH);
  localparam logic [16:0] CHAIN1 = 17'(`SLOT1_CERT0_LENGTH + `SLOT1_CERT1_LENGTH +
    `SLOT1_CERT2_LENGTH + `SLOT1_CERT3_LENGTH);
  localparam logic [16:0] CHAIN2 = 17'(`SLOT2_CERT0_LENGTH + `SLOT2_CERT1_LENGTH +
    `SLOT2_CERT2_LENGTH + `SLOT2_CERT3_LENGTH + `SLOT2_CERT4_LENGTH);

  always_comb begin
    chain_len = '0;
    base      = '0;
    case (slot)
      SLOT_0: begin chain_len = CHAIN0; base = ROM_AW'(SLOT0_BASE); end
      SLOT_1: begin chain_len = CHAIN1; base = ROM_AW'(SLOT1_BASE); end
      SLOT_2: begin chain_len = CHAIN2; base = ROM_AW'(SLOT2_BASE); end
      default: ;
    endcase
  end
endmodule

// File: rtl/get_cert_responder.sv
// GET_CERTIFICATE responder: validates slot/offset, streams a chain portion from ROM.
// Optional per-request size cap: GET_CERT_RESP_CHUNK_LIMIT_EN (limit MAX_CHUNK).
module get_cert_responder
  import get_cert_responder_pkg::*;
#(
  parameter int MAX_CHUNK = 256,
  parameter int ROM_AW    = 12
) (
  input logic                 clk,
  input logic                 reset,
  get_cert_responder_if.slave bus
);
`ifdef GET_CERT_RESP_CHUNK_LIMIT_EN
  localparam logic [16:0] CHUNK_CAP = 17'(MAX_CHUNK);
`else
  // All ones can never bind against a 16-bit length, so MAX_CHUNK has no effect.
  localparam logic [16:0] CHUNK_CAP = 17'h1_FFFF | 17'(MAX_CHUNK);
`endif

  state_t            state, state_nx;
  logic [HDR_W-1:0]  header_q;
  logic [15:0]       offset_q, length_q, count;
  slot_t             slot;
  logic [16:0]       chain_len, avail, portion;
  logic [ROM_AW-1:0] base, rom_addr_q;
  logic [7:0]        error_nx, error_q, tx_data_q;
  logic [HDR_W-1:0]  resp_header_q;
  logic [15:0]       portion_q, remainder_q;
  logic              last;

  assign slot = slot_of(header_q);

  cert_chain_len #(.ROM_AW(ROM_AW)) u_chain_len (
    .slot      (slot),
    .chain_len (chain_len),
    .base      (base)
  );

  // avail wraps when the offset is out of range; it is only used once that case is excluded.
  always_comb begin
    avail   = chain_len - {1'b0, offset_q};
    portion = min17(min17({1'b0, length_q}, avail), CHUNK_CAP);
  end

  assign last = (state == SEND) && (count == portion_q - 16'd1);

  always_comb begin
    state_nx = state;
    error_nx = ERR_NONE;
    case (state)
      IDLE:   if (bus.Enable) state_nx = DECODE;
      DECODE: begin
        if (slot == SLOT_NONE) begin
          error_nx = ERR_INVALID_REQUEST;
          state_nx = DONE;
        end else if ({1'b0, offset_q} >= chain_len) begin
          error_nx = ERR_INVALID_OFFSET;
          state_nx = DONE;
        end else if (portion == '0) begin
          state_nx = DONE;
        end else begin
          state_nx = FETCH;
        end
      end
      FETCH:   state_nx = WAIT;
      WAIT:    state_nx = SEND;
      SEND:    if (bus.tx_ready) state_nx = last ? DONE : FETCH;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && bus.Enable) begin
      header_q <= bus.header;
      offset_q <= bus.payload[PAY_W-1 -: 16];
      length_q <= bus.payload[PAY_W-17 -: 16];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      count         <= '0;
      rom_addr_q    <= '0;
      tx_data_q     <= '0;
      resp_header_q <= '0;
      portion_q     <= '0;
      remainder_q   <= '0;
      error_q       <= ERR_NONE;
    end else begin
      state <= state_nx;
      case (state)
        DECODE: begin
          error_q    <= error_nx;
          count      <= '0;
          rom_addr_q <= ROM_AW'(32'(base) + 32'(offset_q));
          if (error_nx != ERR_NONE) begin
            resp_header_q <= HEADER_ERROR_RESP;
            portion_q     <= '0;
            remainder_q   <= '0;
          end else begin
            resp_header_q <= HEADER_CERTIFICATE_RESP;
            portion_q     <= portion[15:0];
            remainder_q   <= 16'(avail - portion);
          end
        end
        WAIT: tx_data_q <= bus.rom_data;
        SEND: if (bus.tx_ready) begin
          count      <= count + 16'd1;
          rom_addr_q <= rom_addr_q + ROM_AW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.rom_addr      = rom_addr_q;
  assign bus.tx_data       = tx_data_q;
  assign bus.tx_valid      = (state == SEND);
  assign bus.tx_last       = last;
  assign bus.resp_header   = resp_header_q;
  assign bus.portion_len   = portion_q;
  assign bus.remainder_len = remainder_q;
  assign bus.error_code    = error_q;
  assign bus.Ack_out       = (state == DONE);
  assign bus.busy          = (state != IDLE);
endmodule

// File: tb/tb_get_cert_responder.sv
// Directed bench for get_cert_responder: chains of 630/180/100 bytes at bases 0/1024/2048.
module tb_get_cert_responder;
  import get_cert_responder_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   ack_count = 0;

  get_cert_responder_if #(.ROM_AW(12)) bus ();

  get_cert_responder #(.MAX_CHUNK(256), .ROM_AW(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_fn(input logic [11:0] a);
    return a[7:0] + {a[11:8], 4'h3};
  endfunction

  always @(posedge clk) begin
    bus.rom_data <= rom_fn(bus.rom_addr);
    if (bus.Ack_out === 1'b1) ack_count <= ack_count + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 1 (DECODE) of the new request.
  task automatic start_req(input logic [31:0] hdr, input logic [15:0] off, input logic [15:0] len);
    bus.Enable  = 1'b1;
    bus.header  = hdr;
    bus.payload = {off, len};
    tick();
    bus.Enable  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.Enable = 1'b1;
    bus.header = `HEADER_CERTIFICATE_SLOT0;
    bus.payload = {16'd0, 16'd4};
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.tx_valid !== 1'b0 || bus.tx_last !== 1'b0 || bus.Ack_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b valid=%b last=%b ack=%b, expected all 0",
               bus.busy, bus.tx_valid, bus.tx_last, bus.Ack_out);
    end
    checks++;
    if (bus.rom_addr !== 12'h0 || bus.tx_data !== 8'h0 || bus.resp_header !== 32'h0 ||
        bus.portion_len !== 16'h0 || bus.remainder_len !== 16'h0 || bus.error_code !== 8'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%h data=%h hdr=%h por=%0d rem=%0d err=%h, expected all 0",
               bus.rom_addr, bus.tx_data, bus.resp_header, bus.portion_len, bus.remainder_len,
               bus.error_code);
    end
    bus.Enable = 1'b0;
    reset = 1'b1;
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: busy=%b expected 0", bus.busy);
    end
  endtask

  task automatic run_stream(input string name, input logic [31:0] hdr, input logic [15:0] off,
                            input logic [15:0] len, input logic [11:0] base, input int n,
                            input logic [15:0] exp_rem, input bit poke_enable);
    int acks0;
    logic [11:0] a;
    acks0 = ack_count;
    bus.tx_ready = 1'b1;
    start_req(hdr, off, len);
    tick();
    a = base + off[11:0];
    checks++;
    if (bus.rom_addr !== a || bus.tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s first_fetch: addr=%h valid=%b, expected addr=%h valid=0", name, bus.rom_addr, bus.tx_valid, a);
    end
    tick();
    tick();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== rom_fn(a) || bus.tx_last !== (i == n - 1)) begin
        errors++;
        $display("FAIL %s byte%0d: valid=%b data=%h last=%b, expected valid=1 data=%h last=%b",
                 name, i, bus.tx_valid, bus.tx_data, bus.tx_last, rom_fn(a), (i == n - 1));
      end
      if (poke_enable && i == 0) begin
        bus.Enable = 1'b1;
        bus.header = `HEADER_CERTIFICATE_SLOT1;
      end
      tick();
      bus.Enable = 1'b0;
      a = a + 12'd1;
      if (i < n - 1) begin
        checks++;
        if (bus.rom_addr !== a || bus.tx_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s fetch%0d: addr=%h valid=%b, expected addr=%h valid=0", name, i + 1, bus.rom_addr, bus.tx_valid, a);
        end
        tick();
        tick();
      end
    end
    checks++;
    if (bus.Ack_out !== 1'b1 || bus.portion_len !== 16'(n) || bus.remainder_len !== exp_rem ||
        bus.error_code !== 8'h00 || bus.resp_header !== HEADER_CERTIFICATE_RESP) begin
      errors++;
      $display("FAIL %s done: ack=%b por=%0d rem=%0d err=%h hdr=%h, expected ack=1 por=%0d rem=%0d err=00 hdr=%h",
               name, bus.Ack_out, bus.portion_len, bus.remainder_len, bus.error_code, bus.resp_header,
               n, exp_rem, HEADER_CERTIFICATE_RESP);
    end
    tick();
    checks++;
    if (bus.Ack_out !== 1'b0 || bus.busy !== 1'b0 || ack_count !== acks0 + 1) begin
      errors++;
      $display("FAIL %s ack_once: ack=%b busy=%b acks=%0d, expected ack=0 busy=0 acks=%0d",
               name, bus.Ack_out, bus.busy, ack_count, acks0 + 1);
    end
  endtask

  // Requests that finish without streaming: Ack_out at cycle 2.
  task automatic test_no_stream(input string name, input logic [31:0] hdr, input logic [15:0] off,
                                input logic [15:0] len, input logic [7:0] exp_err,
                                input logic [31:0] exp_hdr, input logic [15:0] exp_rem);
    bus.tx_ready = 1'b1;
    start_req(hdr, off, len);
    checks++;
    if (bus.busy !== 1'b1 || bus.Ack_out !== 1'b0 || bus.tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s cycle1: busy=%b ack=%b valid=%b, expected busy=1 ack=0 valid=0",
               name, bus.busy, bus.Ack_out, bus.tx_valid);
    end
    tick();
    checks++;
    if (bus.Ack_out !== 1'b1 || bus.tx_valid !== 1'b0 || bus.error_code !== exp_err ||
        bus.resp_header !== exp_hdr || bus.portion_len !== 16'd0 || bus.remainder_len !== exp_rem) begin
      errors++;
      $display("FAIL %s cycle2: ack=%b valid=%b err=%h hdr=%h por=%0d rem=%0d, expected ack=1 valid=0 err=%h hdr=%h por=0 rem=%0d",
               name, bus.Ack_out, bus.tx_valid, bus.error_code, bus.resp_header, bus.portion_len,
               bus.remainder_len, exp_err, exp_hdr, exp_rem);
    end
    tick();
    checks++;
    if (bus.Ack_out !== 1'b0 || bus.busy !== 1'b0 || bus.error_code !== exp_err) begin
      errors++;
      $display("FAIL %s after: ack=%b busy=%b err=%h, expected ack=0 busy=0 err=%h",
               name, bus.Ack_out, bus.busy, bus.error_code, exp_err);
    end
  endtask

  task automatic test_stall_reset();
    int acks0;
    logic [7:0] exp_byte;
    acks0 = ack_count;
    exp_byte = rom_fn(12'd1034);
    bus.tx_ready = 1'b0;
    start_req(`HEADER_CERTIFICATE_SLOT1, 16'd10, 16'd5);
    tick();
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp_byte || bus.rom_addr !== 12'd1034 || bus.Ack_out !== 1'b0) begin
        errors++;
        $display("FAIL stall%0d: valid=%b data=%h addr=%h ack=%b, expected valid=1 data=%h addr=40a ack=0",
                 i, bus.tx_valid, bus.tx_data, bus.rom_addr, bus.Ack_out, exp_byte);
      end
      bus.Enable = (i == 1);
      bus.header = `HEADER_CERTIFICATE_SLOT2;
      tick();
    end
    bus.Enable = 1'b0;
    reset = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.tx_valid !== 1'b0 || bus.tx_last !== 1'b0 || bus.Ack_out !== 1'b0 ||
        bus.rom_addr !== 12'h0 || bus.tx_data !== 8'h0 || bus.resp_header !== 32'h0 ||
        bus.portion_len !== 16'h0 || bus.remainder_len !== 16'h0 || bus.error_code !== 8'h0) begin
      errors++;
      $display("FAIL midstream_reset: busy=%b valid=%b ack=%b addr=%h data=%h hdr=%h por=%0d rem=%0d err=%h, expected all 0",
               bus.busy, bus.tx_valid, bus.Ack_out, bus.rom_addr, bus.tx_data, bus.resp_header,
               bus.portion_len, bus.remainder_len, bus.error_code);
    end
    reset = 1'b1;
    bus.tx_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b0 || ack_count !== acks0) begin
      errors++;
      $display("FAIL abandon_no_ack: busy=%b acks=%0d, expected busy=0 acks=%0d", bus.busy, ack_count, acks0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Enable   = 1'b0;
    bus.header   = '0;
    bus.payload  = '0;
    bus.tx_ready = 1'b1;
    #1;
    test_reset();
    run_stream("slot0_len4", `HEADER_CERTIFICATE_SLOT0, 16'd0, 16'd4, 12'd0, 4, 16'd626, 1'b0);
    run_stream("slot2_tail", `HEADER_CERTIFICATE_SLOT2, 16'd97, 16'd10, 12'd2048, 3, 16'd0, 1'b0);
    run_stream("slot1_enable_ignored", `HEADER_CERTIFICATE_SLOT1, 16'd178, 16'd2, 12'd1024, 2, 16'd0, 1'b1);
    test_no_stream("bad_header", 32'h0, 16'd0, 16'd4, ERR_INVALID_REQUEST, HEADER_ERROR_RESP, 16'd0);
    test_no_stream("bad_offset", `HEADER_CERTIFICATE_SLOT1, 16'd180, 16'd5, ERR_INVALID_OFFSET, HEADER_ERROR_RESP, 16'd0);
    test_no_stream("zero_len", `HEADER_CERTIFICATE_SLOT1, 16'd5, 16'd0, ERR_NONE, HEADER_CERTIFICATE_RESP, 16'd175);
`ifdef GET_CERT_RESP_CHUNK_LIMIT_EN
    run_stream("slot0_len600", `HEADER_CERTIFICATE_SLOT0, 16'd0, 16'd600, 12'd0, 256, 16'd374, 1'b0);
`else
    run_stream("slot0_len600", `HEADER_CERTIFICATE_SLOT0, 16'd0, 16'd600, 12'd0, 600, 16'd30, 1'b0);
`endif
    test_stall_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
